writeback_unit_l7: RTL and testbench
====================================

WRITEBACK_UNIT_L7 -- requirements
Module: writeback_unit_l7

Interface
REQ-001 SHALL provide parameter p_num_pipes, default 2, number of execute-unit producer channels (2..8).
REQ-002 SHALL provide parameter p_seq_num_bits, default 5, width of the instruction sequence number.
REQ-003 SHALL provide parameter p_phys_addr_bits, default 6, width of the physical register index.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port x_val, input, p_num_pipes; per-channel valid from the execute units.
REQ-007 SHALL have port x_rdy, output, p_num_pipes; per-channel ready to the execute units.
REQ-008 SHALL have ports x_pc (32), x_seq_num (p_seq_num_bits), x_waddr (5), x_wdata (32), x_wen (1), x_preg and x_ppreg (p_phys_addr_bits each); all inputs, flat-packed per channel, channel i in slice i.
REQ-009 SHALL have ports rf_wen (1), rf_preg (p_phys_addr_bits), rf_wdata (32); outputs forming the physical register-file write port.
REQ-010 SHALL have ports cmp_val (1, output), cmp_rdy (1, input), cmp_pc (32), cmp_seq_num, cmp_waddr (5), cmp_wen (1), cmp_preg, cmp_ppreg; outputs except cmp_rdy; completion to the commit stage.
REQ-011 SHALL have ports byp_val (1), byp_preg (p_phys_addr_bits), byp_data (32); outputs forming the operand-bypass source.

Function
REQ-012 SHALL hold one output entry register (val plus all x_* fields); the cmp_* outputs are driven directly from it.
REQ-013 SHALL assert can_accept = !entry.val | cmp_rdy; the entry advances only on a cmp transfer (cmp_val & cmp_rdy).
REQ-014 SHALL grant round-robin: among set x_val bits, select the lowest index >= rr_ptr, wrapping to index 0.
REQ-015 SHALL drive x_rdy[i] = grant[i] & can_accept; at most one x_rdy bit high per cycle; x_rdy SHALL NOT depend on x_val of the granted channel combinationally beyond grant selection.
REQ-016 On a transfer from channel g, rr_ptr SHALL become (g+1) mod p_num_pipes, wrapping at the top; with no transfer, rr_ptr holds.
REQ-017 SHALL load the entry on a channel transfer; latency is 1 (accepted in cycle t, cmp_val high in t+1).
REQ-018 Simultaneous drain and accept SHALL replace the entry with the new input in the same edge (full throughput, 1/cycle).
REQ-019 Drain without accept SHALL clear entry.val; no drain and no accept SHALL hold the entry unchanged, including while cmp_rdy=0.
REQ-020 rf_wen SHALL = cmp_val & cmp_rdy & cmp_wen & (cmp_waddr != 0); rf_preg = entry.preg; rf_wdata = entry.wdata.
REQ-021 Entries with wen=0 (stores) SHALL still produce a completion, with no register-file write.
REQ-022 byp_val SHALL = entry.val & entry.wen & (entry.waddr != 0), independent of cmp_rdy; byp_preg and byp_data follow the entry.
REQ-023 cmp_* data outputs other than cmp_val are don't-care while cmp_val=0.

Reset
REQ-024 During rst, x_rdy, cmp_val, rf_wen and byp_val SHALL be 0; the entry is invalidated and rr_ptr = 0.
REQ-025 Reset mid-operation SHALL discard any held entry without a completion or register-file write; the first transfer after reset takes one cycle.

Verification
REQ-026 Single load: ch0 val, seq=3, waddr=5, preg=12, wdata=0xDEADBEEF, wen=1, cmp_rdy=1 -> next cycle cmp_val=1, rf_wen=1, rf_preg=12, rf_wdata=0xDEADBEEF.
REQ-027 Contention: ch0 and ch1 valid continuously, cmp_rdy=1 -> grants alternate 0,1,0,1; one completion per cycle, in grant order.
REQ-028 Backpressure: entry valid, cmp_rdy=0 for 3 cycles -> x_rdy=0, entry stable, rf_wen=0, byp_val=1; cmp_rdy rises -> one completion, new input accepted on the same edge.
REQ-029 Store and x0: wen=0, seq=7 -> cmp_val=1 with rf_wen=0; wen=1 with waddr=0 -> cmp_val=1 with rf_wen=0 and byp_val=0.
REQ-030 Reset mid-flight: entry valid, rst pulsed for 1 cycle -> cmp_val=0 next cycle, rr_ptr=0 (ch0 wins next contention).

Source files
------------

// File: rtl/writeback_unit_l7.sv
// Writeback stage.
// A round-robin arbiter picks one execute-unit channel. Its result goes into a
// single output entry. That entry drives the completion port to commit, the
// register-file write port and the operand-bypass source.
module writeback_unit_l7 #(
  parameter int p_num_pipes      = 2,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [p_num_pipes-1:0]                   x_val,
  output logic [p_num_pipes-1:0]                   x_rdy,
  input  logic [32*p_num_pipes-1:0]                x_pc,
  input  logic [p_seq_num_bits*p_num_pipes-1:0]    x_seq_num,
  input  logic [5*p_num_pipes-1:0]                 x_waddr,
  input  logic [32*p_num_pipes-1:0]                x_wdata,
  input  logic [p_num_pipes-1:0]                   x_wen,
  input  logic [p_phys_addr_bits*p_num_pipes-1:0]  x_preg,
  input  logic [p_phys_addr_bits*p_num_pipes-1:0]  x_ppreg,
  output logic                                     rf_wen,
  output logic [p_phys_addr_bits-1:0]              rf_preg,
  output logic [31:0]                              rf_wdata,
  output logic                                     cmp_val,
  input  logic                                     cmp_rdy,
  output logic [31:0]                              cmp_pc,
  output logic [p_seq_num_bits-1:0]                cmp_seq_num,
  output logic [4:0]                               cmp_waddr,
  output logic                                     cmp_wen,
  output logic [p_phys_addr_bits-1:0]              cmp_preg,
  output logic [p_phys_addr_bits-1:0]              cmp_ppreg,
  output logic                                     byp_val,
  output logic [p_phys_addr_bits-1:0]              byp_preg,
  output logic [31:0]                              byp_data
);

  localparam int PtrW = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

  typedef struct packed {
    logic                        val;
    logic [31:0]                 pc;
    logic [p_seq_num_bits-1:0]   seq;
    logic [4:0]                  waddr;
    logic [31:0]                 wdata;
    logic                        wen;
    logic [p_phys_addr_bits-1:0] preg;
    logic [p_phys_addr_bits-1:0] ppreg;
  } entry_t;

  entry_t            entry_q, entry_d;
  logic [PtrW-1:0]   rrPtr_q, rrPtr_d;
  logic [PtrW-1:0]   grantIdx;
  logic              grantAny;
  logic [p_num_pipes-1:0] grant;
  logic              canAccept;
  logic              inXfer;
  logic              cmpXfer;
  int                scanIdx;

  logic [31:0]                 pcArr    [p_num_pipes];
  logic [p_seq_num_bits-1:0]   seqArr   [p_num_pipes];
  logic [4:0]                  waddrArr [p_num_pipes];
  logic [31:0]                 wdataArr [p_num_pipes];
  logic [p_phys_addr_bits-1:0] pregArr  [p_num_pipes];
  logic [p_phys_addr_bits-1:0] ppregArr [p_num_pipes];

  // Split the flat-packed channel buses into per-channel fields
  for (genvar i = 0; i < p_num_pipes; i++) begin : g_unpack
    assign pcArr[i]    = x_pc[i*32 +: 32];
    assign seqArr[i]   = x_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
    assign waddrArr[i] = x_waddr[i*5 +: 5];
    assign wdataArr[i] = x_wdata[i*32 +: 32];
    assign pregArr[i]  = x_preg[i*p_phys_addr_bits +: p_phys_addr_bits];
    assign ppregArr[i] = x_ppreg[i*p_phys_addr_bits +: p_phys_addr_bits];
  end

  // Round-robin search: first valid channel at or above the pointer, wrapping to 0
  always_comb begin
    grantIdx = '0;
    grantAny = 1'b0;
    scanIdx  = 0;
    for (int k = 0; k < p_num_pipes; k++) begin
      scanIdx = int'(rrPtr_q) + k;
      if (scanIdx >= p_num_pipes) scanIdx = scanIdx - p_num_pipes;
      if (!grantAny && x_val[scanIdx]) begin
        grantAny = 1'b1;
        grantIdx = PtrW'(scanIdx);
      end
    end
  end

  // One-hot grant; ready is the grant qualified by room in the output entry
  always_comb begin
    grant = '0;
    if (grantAny) grant[grantIdx] = 1'b1;
  end

  assign cmp_val   = entry_q.val & ~rst;
  assign cmpXfer   = cmp_val & cmp_rdy;
  assign canAccept = ~rst & (~entry_q.val | cmp_rdy);
  assign x_rdy     = grant & {p_num_pipes{canAccept}};
  assign inXfer    = grantAny & canAccept;

  // Next entry: a new result overwrites (even while draining); a drain alone empties it
  always_comb begin
    entry_d = entry_q;
    rrPtr_d = rrPtr_q;
    if (inXfer) begin
      entry_d.val   = 1'b1;
      entry_d.pc    = pcArr[grantIdx];
      entry_d.seq   = seqArr[grantIdx];
      entry_d.waddr = waddrArr[grantIdx];
      entry_d.wdata = wdataArr[grantIdx];
      entry_d.wen   = x_wen[grantIdx];
      entry_d.preg  = pregArr[grantIdx];
      entry_d.ppreg = ppregArr[grantIdx];
      if (int'(grantIdx) == p_num_pipes - 1) rrPtr_d = '0;
      else                                   rrPtr_d = grantIdx + 1'b1;
    end else if (cmpXfer) begin
      entry_d.val = 1'b0;
    end
  end

  // Entry and arbitration pointer registers; reset drops any held result
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
      rrPtr_q <= '0;
    end else begin
      entry_q <= entry_d;
      rrPtr_q <= rrPtr_d;
    end
  end

  assign cmp_pc      = entry_q.pc;
  assign cmp_seq_num = entry_q.seq;
  assign cmp_waddr   = entry_q.waddr;
  assign cmp_wen     = entry_q.wen;
  assign cmp_preg    = entry_q.preg;
  assign cmp_ppreg   = entry_q.ppreg;

  // Register x0 is never written or bypassed; stores complete without a write
  assign rf_wen   = cmpXfer & entry_q.wen & (entry_q.waddr != 5'd0);
  assign rf_preg  = entry_q.preg;
  assign rf_wdata = entry_q.wdata;

  assign byp_val  = cmp_val & entry_q.wen & (entry_q.waddr != 5'd0);
  assign byp_preg = entry_q.preg;
  assign byp_data = entry_q.wdata;

endmodule

// File: tb/tb_writeback_unit_l7.sv
// Testbench for writeback_unit_l7.
// Directed stimulus pushes expected completions into a queue. A monitor pops
// that queue on every completion handshake.
module tb_writeback_unit_l7;

  localparam int N = 2;
  localparam int S = 5;
  localparam int P = 6;

  logic            clk;
  logic            rst;
  logic [N-1:0]    x_val;
  logic [N-1:0]    x_rdy;
  logic [32*N-1:0] x_pc;
  logic [S*N-1:0]  x_seq_num;
  logic [5*N-1:0]  x_waddr;
  logic [32*N-1:0] x_wdata;
  logic [N-1:0]    x_wen;
  logic [P*N-1:0]  x_preg;
  logic [P*N-1:0]  x_ppreg;
  logic            rf_wen;
  logic [P-1:0]    rf_preg;
  logic [31:0]     rf_wdata;
  logic            cmp_val;
  logic            cmp_rdy;
  logic [31:0]     cmp_pc;
  logic [S-1:0]    cmp_seq_num;
  logic [4:0]      cmp_waddr;
  logic            cmp_wen;
  logic [P-1:0]    cmp_preg;
  logic [P-1:0]    cmp_ppreg;
  logic            byp_val;
  logic [P-1:0]    byp_preg;
  logic [31:0]     byp_data;

  writeback_unit_l7 #(.p_num_pipes(N), .p_seq_num_bits(S), .p_phys_addr_bits(P)) dut (
    .clk(clk), .rst(rst),
    .x_val(x_val), .x_rdy(x_rdy),
    .x_pc(x_pc), .x_seq_num(x_seq_num), .x_waddr(x_waddr), .x_wdata(x_wdata),
    .x_wen(x_wen), .x_preg(x_preg), .x_ppreg(x_ppreg),
    .rf_wen(rf_wen), .rf_preg(rf_preg), .rf_wdata(rf_wdata),
    .cmp_val(cmp_val), .cmp_rdy(cmp_rdy), .cmp_pc(cmp_pc), .cmp_seq_num(cmp_seq_num),
    .cmp_waddr(cmp_waddr), .cmp_wen(cmp_wen), .cmp_preg(cmp_preg), .cmp_ppreg(cmp_ppreg),
    .byp_val(byp_val), .byp_preg(byp_preg), .byp_data(byp_data)
  );

  typedef struct {
    logic [S-1:0] seq;
    logic [31:0]  pc;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic         wen;
    logic [P-1:0] preg;
    logic [P-1:0] ppreg;
  } exp_t;

  exp_t sbQ[$];
  exp_t curPay[N];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation
  function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Drive one channel's payload and remember it for building expectations
  task automatic applyStimulus(input int ch, input logic [S-1:0] seq, input logic [4:0] waddr,
                               input logic [31:0] wdata, input logic wen, input logic [P-1:0] preg);
    curPay[ch].seq   = seq;
    curPay[ch].pc    = 32'h1000 + 32'(int'(seq) * 4);
    curPay[ch].waddr = waddr;
    curPay[ch].wdata = wdata;
    curPay[ch].wen   = wen;
    curPay[ch].preg  = preg;
    curPay[ch].ppreg = ~preg;
    x_pc[ch*32 +: 32]    = curPay[ch].pc;
    x_seq_num[ch*S +: S] = seq;
    x_waddr[ch*5 +: 5]   = waddr;
    x_wdata[ch*32 +: 32] = wdata;
    x_wen[ch]            = wen;
    x_preg[ch*P +: P]    = preg;
    x_ppreg[ch*P +: P]   = ~preg;
  endtask

  task automatic pushFromChan(input int ch);
    sbQ.push_back(curPay[ch]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both channels valid; the expected grant alternates starting at startCh
  task automatic contention(input int startCh, input int n, input int base0, input int base1);
    int cnt[N];
    int expCh;
    cnt[0] = 0;
    cnt[1] = 0;
    tick();
    applyStimulus(0, S'(base0), 5'(base0), 32'hC0DE_0000 + 32'(base0), 1'b1, P'(base0));
    applyStimulus(1, S'(base1), 5'(base1), 32'hC0DE_0000 + 32'(base1), 1'b1, P'(base1));
    x_val   = 2'b11;
    cmp_rdy = 1'b1;
    for (int k = 0; k < n; k++) begin
      expCh = startCh ^ (k % 2);
      pushFromChan(expCh);
      @(negedge clk);
      checkOutput("x_rdy_contend", 64'(x_rdy), 64'(2'b01 << expCh));
      tick();
      cnt[expCh]++;
      if (expCh == 0)
        applyStimulus(0, S'(base0 + cnt[0]), 5'(base0 + cnt[0]), 32'hC0DE_0000 + 32'(base0 + cnt[0]), 1'b1, P'(base0 + cnt[0]));
      else
        applyStimulus(1, S'(base1 + cnt[1]), 5'(base1 + cnt[1]), 32'hC0DE_0000 + 32'(base1 + cnt[1]), 1'b1, P'(base1 + cnt[1]));
    end
    x_val = 2'b00;
    @(negedge clk);
  endtask

  // Monitor: every completion handshake must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && cmp_val && cmp_rdy) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_completion: got seq 0x%0h expected none", cmp_seq_num);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("cmp_seq_num", 64'(cmp_seq_num), 64'(e.seq));
        checkOutput("cmp_pc", 64'(cmp_pc), 64'(e.pc));
        checkOutput("cmp_waddr", 64'(cmp_waddr), 64'(e.waddr));
        checkOutput("cmp_wen", 64'(cmp_wen), 64'(e.wen));
        checkOutput("cmp_preg", 64'(cmp_preg), 64'(e.preg));
        checkOutput("cmp_ppreg", 64'(cmp_ppreg), 64'(e.ppreg));
        checkOutput("rf_wen", 64'(rf_wen), 64'(e.wen && (e.waddr != 5'd0)));
        checkOutput("rf_preg", 64'(rf_preg), 64'(e.preg));
        checkOutput("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
      end
    end
  end

  // Directed sequence
  initial begin
    rst       = 1'b1;
    x_val     = '0;
    cmp_rdy   = 1'b1;
    x_pc      = '0;
    x_seq_num = '0;
    x_waddr   = '0;
    x_wdata   = '0;
    x_wen     = '0;
    x_preg    = '0;
    x_ppreg   = '0;
    applyStimulus(0, 5'd1, 5'd1, 32'h1, 1'b1, 6'd1);
    applyStimulus(1, 5'd2, 5'd2, 32'h2, 1'b1, 6'd2);
    x_val = 2'b11;
    @(negedge clk);
    checkOutput("rst_x_rdy", 64'(x_rdy), 64'h0);
    checkOutput("rst_cmp_val", 64'(cmp_val), 64'h0);
    checkOutput("rst_rf_wen", 64'(rf_wen), 64'h0);
    checkOutput("rst_byp_val", 64'(byp_val), 64'h0);
    tick();
    tick();
    rst   = 1'b0;
    x_val = 2'b00;

    // Single load on channel 0, completes one cycle later
    tick();
    applyStimulus(0, 5'd3, 5'd5, 32'hDEADBEEF, 1'b1, 6'd12);
    x_val = 2'b01;
    pushFromChan(0);
    @(negedge clk);
    checkOutput("load_x_rdy", 64'(x_rdy), 64'h1);
    tick();
    x_val = 2'b00;
    @(negedge clk);
    checkOutput("load_cmp_val", 64'(cmp_val), 64'h1);
    checkOutput("load_rf_wen", 64'(rf_wen), 64'h1);
    checkOutput("load_rf_preg", 64'(rf_preg), 64'd12);
    checkOutput("load_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    checkOutput("load_byp_val", 64'(byp_val), 64'h1);
    tick();
    @(negedge clk);
    checkOutput("load_drained", 64'(cmp_val), 64'h0);

    // Store on channel 1: completes with no register write
    tick();
    applyStimulus(1, 5'd7, 5'd3, 32'h1111_2222, 1'b0, 6'd20);
    x_val = 2'b10;
    pushFromChan(1);
    @(negedge clk);
    checkOutput("store_x_rdy", 64'(x_rdy), 64'h2);
    tick();
    x_val = 2'b00;
    @(negedge clk);
    checkOutput("store_cmp_val", 64'(cmp_val), 64'h1);
    checkOutput("store_rf_wen", 64'(rf_wen), 64'h0);

    // Pointer is back at 0: grants 0,1,0,1
    contention(0, 4, 10, 20);

    // Write to x0: completes, no write, no bypass
    tick();
    applyStimulus(1, 5'd9, 5'd0, 32'h33, 1'b1, 6'd21);
    x_val = 2'b10;
    pushFromChan(1);
    tick();
    x_val = 2'b00;
    @(negedge clk);
    checkOutput("x0_cmp_val", 64'(cmp_val), 64'h1);
    checkOutput("x0_rf_wen", 64'(rf_wen), 64'h0);
    checkOutput("x0_byp_val", 64'(byp_val), 64'h0);

    // Backpressure: entry held three cycles, then drain and accept on one edge
    tick();
    cmp_rdy = 1'b0;
    applyStimulus(1, 5'd15, 5'd6, 32'hCAFE_F00D, 1'b1, 6'd30);
    x_val = 2'b10;
    pushFromChan(1);
    @(negedge clk);
    checkOutput("bp_load_x_rdy", 64'(x_rdy), 64'h2);
    tick();
    applyStimulus(0, 5'd16, 5'd7, 32'h0BAD_C0DE, 1'b1, 6'd31);
    x_val = 2'b01;
    pushFromChan(0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_x_rdy", 64'(x_rdy), 64'h0);
      checkOutput("bp_cmp_val", 64'(cmp_val), 64'h1);
      checkOutput("bp_seq_stable", 64'(cmp_seq_num), 64'd15);
      checkOutput("bp_rf_wen", 64'(rf_wen), 64'h0);
      checkOutput("bp_byp_val", 64'(byp_val), 64'h1);
      checkOutput("bp_byp_data", 64'(byp_data), 64'hCAFE_F00D);
      tick();
    end
    cmp_rdy = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_x_rdy", 64'(x_rdy), 64'h1);
    tick();
    x_val = 2'b00;
    @(negedge clk);
    checkOutput("bp_next_seq", 64'(cmp_seq_num), 64'd16);
    tick();

    // Reset mid-flight: held entry is dropped and the pointer returns to 0
    cmp_rdy = 1'b0;
    applyStimulus(0, 5'd25, 5'd8, 32'h55, 1'b1, 6'd40);
    x_val = 2'b01;
    tick();
    x_val = 2'b00;
    @(negedge clk);
    checkOutput("mid_cmp_val", 64'(cmp_val), 64'h1);
    tick();
    rst   = 1'b1;
    x_val = 2'b11;
    @(negedge clk);
    checkOutput("mid_rst_cmp_val", 64'(cmp_val), 64'h0);
    checkOutput("mid_rst_byp_val", 64'(byp_val), 64'h0);
    checkOutput("mid_rst_rf_wen", 64'(rf_wen), 64'h0);
    checkOutput("mid_rst_x_rdy", 64'(x_rdy), 64'h0);
    tick();
    rst     = 1'b0;
    x_val   = 2'b00;
    cmp_rdy = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_cmp_val", 64'(cmp_val), 64'h0);
    contention(0, 2, 26, 28);

    tick();
    tick();
    checkOutput("sb_empty", 64'(sbQ.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
